// File: rtl/op2_pkg.sv
// Shared constants for the EX-stage operand-2 selector: select encodings
// and the default datapath widths.
package op2_pkg;

   // Operand-2 source select encodings
   typedef logic [2:0] sel_t;

   localparam sel_t SEL_PB   = 3'b000;  // register-file port B
   localparam sel_t SEL_HI   = 3'b001;  // HI register (bypassed)
   localparam sel_t SEL_LO   = 3'b010;  // LO register (bypassed)
   localparam sel_t SEL_PC   = 3'b011;  // program counter
   localparam sel_t SEL_SEXT = 3'b100;  // sign-extended immediate
   localparam sel_t SEL_LUI  = 3'b101;  // immediate in the upper bits
   localparam sel_t SEL_ZEXT = 3'b110;  // zero-extended immediate
   localparam sel_t SEL_ZERO = 3'b111;  // constant zero

   // Default widths
   localparam int DEF_DATA_W = 32;
   localparam int DEF_IMM_W  = 16;
   localparam int DEF_TAG_W  = 5;
   localparam int DEF_PEND_W = 2;

endpackage

// File: rtl/hilo_regs.sv
// HI/LO register pair with write priority, write-through bypass and the
// counter of outstanding HI/LO-producing mult/div operations.
module hilo_regs
   import op2_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int PEND_W = DEF_PEND_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic              res_valid,
   input  logic [DATA_W-1:0] res_hi,
   input  logic [DATA_W-1:0] res_lo,
   input  logic              mthi,
   input  logic              mtlo,
   input  logic [DATA_W-1:0] mt_data,
   output logic [DATA_W-1:0] hi_q,
   output logic [DATA_W-1:0] lo_q,
   output logic [DATA_W-1:0] hi_byp,
   output logic [DATA_W-1:0] lo_byp,
   output logic              pend_zero,
   output logic              pend_one,
   output logic              err
);

   localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
   localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0] hi_r;
   logic [DATA_W-1:0] lo_r;
   logic [DATA_W-1:0] hi_next_s;
   logic [DATA_W-1:0] lo_next_s;
   logic [PEND_W-1:0] pending_r;
   logic [PEND_W-1:0] pending_next_s;
   logic              pend_full_s;
   logic              issue_ok_s;
   logic              err_set_s;
   logic              err_r;

   assign pend_zero   = (pending_r == {PEND_W{1'b0}});
   assign pend_one    = (pending_r == PEND_ONE);
   assign pend_full_s = (pending_r == PEND_MAX);
   assign issue_ready = !pend_full_s;
   assign issue_ok_s  = issue_valid && !pend_full_s;
   assign err_set_s   = (issue_valid && pend_full_s) || (res_valid && pend_zero);

   // Per-half next value: MT write is younger in program order, so it wins
   always_comb begin
      hi_next_s = hi_r;
      lo_next_s = lo_r;
      if (mthi) begin
         hi_next_s = mt_data;
      end else if (res_valid) begin
         hi_next_s = res_hi;
      end else begin
         hi_next_s = hi_r;
      end
      if (mtlo) begin
         lo_next_s = mt_data;
      end else if (res_valid) begin
         lo_next_s = res_lo;
      end else begin
         lo_next_s = lo_r;
      end
   end

   // Pending counter update; an issue rejected when full or a result at zero leaves it alone
   always_comb begin
      pending_next_s = pending_r;
      case ({issue_ok_s, res_valid && !pend_zero})
         2'b10:   pending_next_s = pending_r + PEND_ONE;
         2'b01:   pending_next_s = pending_r - PEND_ONE;
         default: pending_next_s = pending_r;
      endcase
   end

   // HI/LO, pending counter and sticky error registers
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_r      <= {DATA_W{1'b0}};
         lo_r      <= {DATA_W{1'b0}};
         pending_r <= {PEND_W{1'b0}};
         err_r     <= 1'b0;
      end else begin
         hi_r      <= hi_next_s;
         lo_r      <= lo_next_s;
         pending_r <= pending_next_s;
         err_r     <= err_r || err_set_s;
      end
   end

   // Selection sees the value being written this cycle
   assign hi_byp = hi_next_s;
   assign lo_byp = lo_next_s;
   assign hi_q   = hi_r;
   assign lo_q   = lo_r;
   assign err    = err_r;

endmodule

// File: rtl/operand2_stage.sv
// EX-stage operand-2 selector: picks N from PB/HI/LO/PC/immediate forms,
// stalls HI/LO reads behind outstanding mult/div ops, and hands N to the
// next stage through a one-entry valid/ready output register.
module operand2_stage
   import op2_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int IMM_W  = DEF_IMM_W,
   parameter int TAG_W  = DEF_TAG_W,
   parameter int PEND_W = DEF_PEND_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_sel,
   input  logic [DATA_W-1:0] in_pb,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [IMM_W-1:0]  in_imm,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic              res_valid,
   input  logic [DATA_W-1:0] res_hi,
   input  logic [DATA_W-1:0] res_lo,
   input  logic              mthi,
   input  logic              mtlo,
   input  logic [DATA_W-1:0] mt_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_n,
   output logic [TAG_W-1:0]  out_tag,
   output logic [DATA_W-1:0] hi_q,
   output logic [DATA_W-1:0] lo_q,
   output logic              err
);

   logic [DATA_W-1:0] hi_byp_s;
   logic [DATA_W-1:0] lo_byp_s;
   logic              pend_zero_s;
   logic              pend_one_s;
   logic              reads_hilo_s;
   logic              hazard_s;
   logic              accept_s;
   logic [DATA_W-1:0] sel_n_s;
   logic              out_valid_r;
   logic [DATA_W-1:0] out_n_r;
   logic [TAG_W-1:0]  out_tag_r;

   hilo_regs #(
      .DATA_W (DATA_W),
      .PEND_W (PEND_W)
   ) u_hilo (
      .clk         (clk),
      .reset       (reset),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .res_valid   (res_valid),
      .res_hi      (res_hi),
      .res_lo      (res_lo),
      .mthi        (mthi),
      .mtlo        (mtlo),
      .mt_data     (mt_data),
      .hi_q        (hi_q),
      .lo_q        (lo_q),
      .hi_byp      (hi_byp_s),
      .lo_byp      (lo_byp_s),
      .pend_zero   (pend_zero_s),
      .pend_one    (pend_one_s),
      .err         (err)
   );

   // A HI/LO read must wait for its producer unless the last one completes this cycle
   assign reads_hilo_s = (in_sel == SEL_HI) || (in_sel == SEL_LO);
   assign hazard_s     = reads_hilo_s && !pend_zero_s && !(pend_one_s && res_valid);
   assign in_ready     = !hazard_s && (!out_valid_r || out_ready);
   assign accept_s     = in_valid && in_ready;

   // Operand source mux; pure bit placement of the immediate forms
   always_comb begin
      sel_n_s = {DATA_W{1'b0}};
      case (in_sel)
         SEL_PB:   sel_n_s = in_pb;
         SEL_HI:   sel_n_s = hi_byp_s;
         SEL_LO:   sel_n_s = lo_byp_s;
         SEL_PC:   sel_n_s = in_pc;
         SEL_SEXT: sel_n_s = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
         SEL_LUI:  sel_n_s = {in_imm, {(DATA_W-IMM_W){1'b0}}};
         SEL_ZEXT: sel_n_s = {{(DATA_W-IMM_W){1'b0}}, in_imm};
         SEL_ZERO: sel_n_s = {DATA_W{1'b0}};
         default:  sel_n_s = {DATA_W{1'b0}};
      endcase
   end

   // One-entry output register: load on accept, hold while stalled, drop after transfer
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         out_n_r     <= {DATA_W{1'b0}};
         out_tag_r   <= {TAG_W{1'b0}};
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
         out_n_r     <= sel_n_s;
         out_tag_r   <= in_tag;
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign out_valid = out_valid_r;
   assign out_n     = out_n_r;
   assign out_tag   = out_tag_r;

endmodule

// File: tb/tb_operand2_stage.sv
// Directed bench for operand2_stage: immediate forms, HI/LO hazard and
// bypass, write priority, pending-counter limits, streaming with
// backpressure, and reset during a held transfer.
module tb_operand2_stage;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_sel;
   logic [31:0] in_pb;
   logic [31:0] in_pc;
   logic [15:0] in_imm;
   logic [4:0]  in_tag;
   logic        issue_valid;
   logic        issue_ready;
   logic        res_valid;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        mthi;
   logic        mtlo;
   logic [31:0] mt_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_n;
   logic [4:0]  out_tag;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        err;

   int checks = 0;
   int errors = 0;

   operand2_stage dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sel      (in_sel),
      .in_pb       (in_pb),
      .in_pc       (in_pc),
      .in_imm      (in_imm),
      .in_tag      (in_tag),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .res_valid   (res_valid),
      .res_hi      (res_hi),
      .res_lo      (res_lo),
      .mthi        (mthi),
      .mtlo        (mtlo),
      .mt_data     (mt_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_n       (out_n),
      .out_tag     (out_tag),
      .hi_q        (hi_q),
      .lo_q        (lo_q),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      logic [31:0] exp_q[$];
      logic [31:0] held;
      logic        was_stalled;
      int          sent;
      int          got;
      logic [5:0]  rdy_pat;

      reset = 1'b1; in_valid = 1'b0; in_sel = 3'b000; in_pb = 32'h0; in_pc = 32'h0;
      in_imm = 16'h0; in_tag = 5'h0; issue_valid = 1'b0; res_valid = 1'b0;
      res_hi = 32'h0; res_lo = 32'h0; mthi = 1'b0; mtlo = 1'b0; mt_data = 32'h0;
      out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      settle();
      check("rst_out_valid", {31'h0, out_valid}, 32'h0);
      check("rst_out_n", out_n, 32'h0);
      check("rst_out_tag", {27'h0, out_tag}, 32'h0);
      check("rst_hi", hi_q, 32'h0);
      check("rst_lo", lo_q, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      check("rst_issue_ready", {31'h0, issue_ready}, 32'h1);
      check("rst_pending", {30'h0, dut.u_hilo.pending_r}, 32'h0);

      // Immediate forms back to back at full throughput
      in_valid = 1'b1; in_sel = 3'b100; in_imm = 16'h8001; in_tag = 5'h1A; out_ready = 1'b1;
      settle();
      check("sext_in_ready", {31'h0, in_ready}, 32'h1);
      tick();
      check("sext_valid", {31'h0, out_valid}, 32'h1);
      check("sext_n", out_n, 32'hFFFF8001);
      check("sext_tag", {27'h0, out_tag}, 32'h1A);
      in_sel = 3'b110; in_tag = 5'h03;
      tick();
      check("zext_n", out_n, 32'h00008001);
      check("zext_tag", {27'h0, out_tag}, 32'h03);
      in_sel = 3'b101;
      tick();
      check("lui_n", out_n, 32'h80010000);
      in_sel = 3'b011; in_pc = 32'h0040_0010;
      tick();
      check("pc_n", out_n, 32'h00400010);
      in_sel = 3'b111;
      tick();
      check("zero_n", out_n, 32'h0);
      check("zero_valid", {31'h0, out_valid}, 32'h1);
      in_valid = 1'b0;
      tick();
      check("drain_valid", {31'h0, out_valid}, 32'h0);

      // HI read stalls behind an outstanding op, proceeds with the bypassed result
      issue_valid = 1'b1;
      tick();
      issue_valid = 1'b0;
      in_valid = 1'b1; in_sel = 3'b001;
      settle();
      check("haz_ready_c1", {31'h0, in_ready}, 32'h0);
      tick();
      check("haz_ready_c2", {31'h0, in_ready}, 32'h0);
      check("haz_no_out", {31'h0, out_valid}, 32'h0);
      tick();
      check("haz_ready_c3", {31'h0, in_ready}, 32'h0);
      res_valid = 1'b1; res_hi = 32'hDEAD0001; res_lo = 32'h0000BEEF;
      settle();
      check("haz_ready_res", {31'h0, in_ready}, 32'h1);
      tick();
      res_valid = 1'b0; in_sel = 3'b010;
      check("haz_out_n", out_n, 32'hDEAD0001);
      check("haz_out_valid", {31'h0, out_valid}, 32'h1);
      check("haz_pending", {30'h0, dut.u_hilo.pending_r}, 32'h0);
      check("haz_hi_q", hi_q, 32'hDEAD0001);
      check("haz_err", {31'h0, err}, 32'h0);
      tick();
      in_valid = 1'b0;
      check("lo_out_n", out_n, 32'h0000BEEF);
      tick();

      // Pending counter saturation and error
      issue_valid = 1'b1;
      tick();
      check("pend1", {30'h0, dut.u_hilo.pending_r}, 32'h1);
      check("pend1_ready", {31'h0, issue_ready}, 32'h1);
      tick(); tick();
      check("pend3", {30'h0, dut.u_hilo.pending_r}, 32'h3);
      check("pend3_ready", {31'h0, issue_ready}, 32'h0);
      check("pend3_err", {31'h0, err}, 32'h0);
      tick();
      issue_valid = 1'b0;
      check("over_err", {31'h0, err}, 32'h1);
      check("over_pend", {30'h0, dut.u_hilo.pending_r}, 32'h3);
      res_valid = 1'b1; res_hi = 32'h0; res_lo = 32'h0;
      tick(); tick(); tick();
      res_valid = 1'b0;
      check("drain_pend", {30'h0, dut.u_hilo.pending_r}, 32'h0);
      check("drain_issue_ready", {31'h0, issue_ready}, 32'h1);
      check("err_sticky", {31'h0, err}, 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("err_cleared", {31'h0, err}, 32'h0);

      // MT beats result write for HI; LO takes the result; selection sees the bypass
      res_valid = 1'b1; res_hi = 32'h1; res_lo = 32'h77; mthi = 1'b1; mt_data = 32'h55;
      in_valid = 1'b1; in_sel = 3'b001;
      tick();
      res_valid = 1'b0; mthi = 1'b0; in_valid = 1'b0;
      check("prio_hi", hi_q, 32'h55);
      check("prio_lo", lo_q, 32'h77);
      check("prio_byp_n", out_n, 32'h55);
      check("res_at_zero_err", {31'h0, err}, 32'h1);
      check("res_at_zero_pend", {30'h0, dut.u_hilo.pending_r}, 32'h0);
      mtlo = 1'b1; mt_data = 32'h66;
      tick();
      mtlo = 1'b0;
      check("mtlo_lo", lo_q, 32'h66);
      check("mtlo_hi_kept", hi_q, 32'h55);
      tick();

      // Stream PB operands 1..4 with out_ready pattern 1,0,0,1,1,1 then 1
      rdy_pat = 6'b111001;
      sent = 0; got = 0; held = 32'h0; was_stalled = 1'b0;
      in_sel = 3'b000;
      for (int c = 0; c < 9; c++) begin
         out_ready = (c < 6) ? rdy_pat[c] : 1'b1;
         in_valid  = (sent < 4);
         in_pb     = sent + 1;
         settle();
         if (was_stalled) check("stream_held", out_n, held);
         check("stream_valid", {31'h0, out_valid}, {31'h0, exp_q.size() != 0});
         check("stream_in_ready", {31'h0, in_ready}, {31'h0, (exp_q.size() == 0) || out_ready});
         if (out_valid && out_ready && exp_q.size() != 0) begin
            check("stream_data", out_n, exp_q.pop_front());
            got++;
         end
         if (in_valid && ((exp_q.size() == 0) || out_ready)) begin
            exp_q.push_back(in_pb);
            sent++;
         end
         was_stalled = out_valid && !out_ready;
         held = out_n;
         tick();
      end
      in_valid = 1'b0;
      check("stream_count", got, 32'd4);

      // Reset while a stalled operand is held
      in_valid = 1'b1; in_sel = 3'b000; in_pb = 32'h9; out_ready = 1'b0; issue_valid = 1'b1;
      tick();
      in_valid = 1'b0; issue_valid = 1'b0;
      check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
      check("pre_rst_pend", {30'h0, dut.u_hilo.pending_r}, 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
      check("mid_rst_n", out_n, 32'h0);
      check("mid_rst_hi", hi_q, 32'h0);
      check("mid_rst_lo", lo_q, 32'h0);
      check("mid_rst_pend", {30'h0, dut.u_hilo.pending_r}, 32'h0);
      out_ready = 1'b1;
      tick();
      check("no_replay", {31'h0, out_valid}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
